// File: rtl/fifo_rd_streamer_if.sv
// Valid/ready beat stream carrying one FIFO word plus its burst-end marker.
// Latency: none, wires only.
// Backpressure: beat transfers on m_valid & m_ready; the master holds the beat while m_ready is low.
interface fifo_rd_streamer_if #(
   parameter int DATA_W = 128
);
   logic              m_valid;
   logic              m_ready;
   logic [DATA_W-1:0] m_data;
   logic              m_last;

   modport master (
      output m_valid,
      output m_data,
      output m_last,
      input  m_ready
   );

   modport slave (
      input  m_valid,
      input  m_data,
      input  m_last,
      output m_ready
   );
endinterface

// File: rtl/fifo_rd_streamer.sv
// Drains the my_fifo read port into a registered valid/ready stream with BURST_LEN-beat framing.
// Latency: a word popped at edge N is on m_data from edge N (visible in cycle N+1), one beat per cycle sustained.
// Backpressure: a 2-entry skid buffer absorbs m_ready stalls; pops stop at occupancy 2, m_ready never reaches fifo_rden.
module fifo_rd_streamer #(
   parameter int DATA_W    = 128,
   parameter int BURST_LEN = 4,
   parameter int CNT_W     = 16
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               fifo_empty,
   input  logic [DATA_W-1:0]  fifo_rddata,
   output logic               fifo_rden,
   fifo_rd_streamer_if.master m,
   output logic               o_burst_done,
   output logic [CNT_W-1:0]   o_burst_cnt,
   output logic [1:0]         o_occ
);

   // Beat counter is at least one bit wide so BURST_LEN=1 still builds.
   localparam int              BC_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam logic [BC_W-1:0] BC_LAST = BC_W'(BURST_LEN - 1);

   // One skid-buffer entry: the FIFO word and whether it closes a burst.
   typedef struct packed {
      logic [DATA_W-1:0] dat;
      logic              last;
   } beat_t;

   // Skid-buffer occupancy doubles as the control state.
   typedef enum logic [1:0] {
      OCC_0 = 2'd0,
      OCC_1 = 2'd1,
      OCC_2 = 2'd2
   } occ_t;

   occ_t            occ_q, occ_d;
   beat_t           ent0_q, ent0_d;
   beat_t           ent1_q, ent1_d;
   logic [BC_W-1:0] beat_cnt_q, beat_cnt_d;
   logic            burst_done_q;
   logic [CNT_W-1:0] burst_cnt_q;

   logic  push;
   logic  pop_out;
   logic  last_tag;
   beat_t in_beat;

   // Pop decision uses only registered occupancy so m_ready has no path to fifo_rden.
   assign fifo_rden = rstn & ~fifo_empty & (occ_q != OCC_2);
   assign push      = fifo_rden;
   assign pop_out   = (occ_q != OCC_0) & m.m_ready;

   // Framing is stamped at push time, so stalls downstream never move burst boundaries.
   assign last_tag  = (beat_cnt_q == BC_LAST);
   assign in_beat   = {fifo_rddata, last_tag};

   assign m.m_valid    = (occ_q != OCC_0);
   assign m.m_data     = ent0_q.dat;
   assign m.m_last     = ent0_q.last;
   assign o_occ        = occ_q;
   assign o_burst_done = burst_done_q;
   assign o_burst_cnt  = burst_cnt_q;

   // Skid-buffer next state: entry0 is the head, a new word lands behind whatever stays.
   always_comb begin
      occ_d  = occ_q;
      ent0_d = ent0_q;
      ent1_d = ent1_q;
      case (occ_q)
         OCC_0: begin
            if (push) begin
               ent0_d = in_beat;
               occ_d  = OCC_1;
            end
         end
         OCC_1: begin
            case ({push, pop_out})
               2'b11: ent0_d = in_beat;
               2'b10: begin
                  ent1_d = in_beat;
                  occ_d  = OCC_2;
               end
               2'b01: occ_d = OCC_0;
               default: ;
            endcase
         end
         OCC_2: begin
            // No push is possible here; only the head can leave.
            if (pop_out) begin
               ent0_d = ent1_q;
               occ_d  = OCC_1;
            end
         end
         default: occ_d = OCC_0;
      endcase
   end

   // Burst position advances on every word taken from the FIFO and wraps after the last beat.
   always_comb begin
      beat_cnt_d = beat_cnt_q;
      if (push) begin
         beat_cnt_d = last_tag ? '0 : beat_cnt_q + 1'b1;
      end
   end

   // Buffer and framing registers; reset discards any buffered beats.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         occ_q      <= OCC_0;
         ent0_q     <= '0;
         ent1_q     <= '0;
         beat_cnt_q <= '0;
      end else begin
         occ_q      <= occ_d;
         ent0_q     <= ent0_d;
         ent1_q     <= ent1_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

   // Completed-burst status: pulse and wrapping count on acceptance of a last beat.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         burst_done_q <= 1'b0;
         burst_cnt_q  <= '0;
      end else begin
         burst_done_q <= pop_out & ent0_q.last;
         if (pop_out & ent0_q.last) begin
            burst_cnt_q <= burst_cnt_q + 1'b1;
         end
      end
   end

endmodule
